traffic_checker_gmii: RTL
=========================

TRAFFIC_CHECKER_GMII -- requirements
Module: traffic_checker_gmii

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port gmii_in_rxd, input, 8 bits: receive data.
REQ-004 SHALL have port gmii_in_rx_dv, input, 1 bit: receive data valid.
REQ-005 SHALL have port gmii_in_rx_er, input, 1 bit: receive error.
REQ-006 SHALL have port enable, input, 1 bit: when high, new frames are accepted.
REQ-007 SHALL have port clear_counters, input, 1 bit: synchronous clear of all counters.
REQ-008 SHALL have outputs frame_count, good_count, crc_err_count, preamble_err_count, rx_err_count, runt_count, each 32 bits: event counters.
REQ-009 SHALL have output byte_count, 32 bits: sum of the lengths of all checked frames.
REQ-010 SHALL have output last_len, 16 bits: length of the last frame (bytes after SFD, FCS included).
REQ-011 SHALL have outputs frame_done, 1 bit, and frame_good, 1 bit: per-frame result strobe and its status.
REQ-012 SHALL have parameter MIN_LEN, default 64: minimum legal length in bytes, FCS included.

Function
REQ-013 States: IDLE, PREAMBLE, DATA, DROP.
REQ-014 IDLE: on rx_dv=1 with enable=1 and rxd=0x55, go to PREAMBLE with preamble count 1; any other rxd with rx_dv=1 gives a preamble error and a move to DROP. With enable=0 the frame is ignored (DROP, no counting).
REQ-015 PREAMBLE: rxd=0x55 increments the preamble count. rxd=0xD5 after 1..7 bytes of 0x55 goes to DATA, with CRC preset to 0xFFFFFFFF and length 0. Any other byte, an 8th 0x55, or rx_dv falling gives a preamble error and a move to DROP.
REQ-016 DATA: each rx_dv=1 cycle updates the CRC-32 (poly 0x04C11DB7, reflected, LSB first) and increments the 16-bit length, which saturates at 0xFFFF. rx_er=1 in any cycle sets a sticky rx_err flag.
REQ-017 DATA: rx_dv=0 ends the frame and returns to IDLE in the same cycle.
REQ-018 DROP: stay until rx_dv=0, then go to IDLE; no DATA-state counters update.
REQ-019 End of frame, one cycle after the last rx_dv=1 byte:
- frame_done pulses high for 1 cycle.
- last_len is updated.
- frame_count and byte_count increment.
REQ-020 crc_err: the CRC register differs from residue 0xC704DD7B at end of frame. runt: length < MIN_LEN.
REQ-021 frame_good = no crc_err, no runt, no rx_err. good_count increments if frame_good=1.
REQ-022 At end of frame, each of crc_err_count, runt_count and rx_err_count increments independently for its condition (one frame may bump several).
REQ-023 A preamble error increments preamble_err_count once per frame. It pulses neither frame_done nor frame_count.
REQ-024 Counters wrap modulo 2^32.
REQ-025 clear_counters=1 zeroes all counters and last_len next cycle. If clear and increment coincide, clear wins. The FSM is unaffected.
REQ-026 enable falling mid-frame does not abort that frame; the frame completes and is counted.
REQ-027 frame_good is held between strobes; it is valid only with frame_done.

Reset
REQ-028 reset=1 asynchronously forces:
- state IDLE;
- all counters, last_len, frame_done and frame_good to 0;
- CRC register to 0xFFFFFFFF;
- sticky flags cleared.
REQ-029 A frame in progress at reset is discarded. After release, a frame already under way (rx_dv=1 with rxd≠0x55) is treated per REQ-014.

Structure
REQ-030 A shared package SHALL hold:
- PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5;
- CRC_POLY, CRC_INIT, CRC_RESIDUE;
- MIN_LEN default;
- the state enum.
REQ-031 The CRC-32 byte-update logic SHALL be a combinational sub-module crc32_d8 (inputs crc_in[31:0] and data[7:0]; output crc_out[31:0]).

Verification
REQ-032 Stimulus: 7×0x55, 0xD5, bytes 0x01..0x3C, correct FCS. Response: frame_done once, frame_good=1, last_len=64, good_count=1, byte_count=64.
REQ-033 Stimulus: same frame with the last FCS byte XOR 0x01. Response: crc_err_count=1, good_count=0, frame_good=0.
REQ-034 Stimulus: a valid 60-byte frame (56 data bytes + correct FCS). Response: runt_count=1, crc_err_count=0, frame_good=0, last_len=60.
REQ-035 Stimulus: 3×0x55 followed by 0x11, then 20 bytes. Response: preamble_err_count=1, frame_count=0, no frame_done. Then a good frame: frame_count=1.
REQ-036 Stimulus: rx_er=1 for one cycle mid-DATA of a good 64-byte frame. Response: rx_err_count=1, crc_err_count=0, frame_good=0.
REQ-037 Stimulus: reset asserted mid-DATA, released, then 1000 back-to-back good frames with 12-cycle gaps, and clear_counters on the same cycle as the last frame_done. Response: all counters 0, no phantom frame from the aborted frame.

Source files
------------

// File: rtl/traffic_checker_gmii_pkg.sv
// Shared constants, state encoding and counter bundle for the GMII traffic checker.
// Byte values and the CRC-32 parameters are kept here so the checker and its CRC stage agree.
package traffic_checker_gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC_POLY        = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE     = 32'hC704_DD7B;
    localparam int          MIN_LEN_DEFAULT = 64;
    localparam logic [2:0]  MAX_PREAMBLE    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_e;

    typedef struct packed {
        logic [31:0] frames;
        logic [31:0] good;
        logic [31:0] crc_err;
        logic [31:0] preamble_err;
        logic [31:0] rx_err;
        logic [31:0] runt;
        logic [31:0] bytes;
    } counters_t;

    // Bit-reverse a 32-bit word; converts between LSB-first and MSB-first CRC views.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_checker_gmii_if.sv
// GMII receive bundle: data, data-valid and error, driven by the PHY side (master).
interface traffic_checker_gmii_if;
    logic [7:0] rxd;
    logic       rx_dv;
    logic       rx_er;

    modport master (output rxd, output rx_dv, output rx_er);
    modport slave  (input  rxd, input  rx_dv, input  rx_er);
endinterface

// File: rtl/traffic_checker_gmii_crc32_d8.sv
// Combinational CRC-32 update for one byte, reflected (LSB-first) form.
module crc32_d8
    import traffic_checker_gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/traffic_checker_gmii.sv
// GMII receive-side frame checker: validates preamble/SFD, checks FCS, length and rx_er,
// and keeps wrapping 32-bit event counters plus a per-frame done/good strobe.
module traffic_checker_gmii
    import traffic_checker_gmii_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_checker_gmii_if.slave gmii_in,
    input  logic                  enable,
    input  logic                  clear_counters,
    output logic [31:0]           frame_count,
    output logic [31:0]           good_count,
    output logic [31:0]           crc_err_count,
    output logic [31:0]           preamble_err_count,
    output logic [31:0]           rx_err_count,
    output logic [31:0]           runt_count,
    output logic [31:0]           byte_count,
    output logic [15:0]           last_len,
    output logic                  frame_done,
    output logic                  frame_good
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    state_e      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [15:0] len_q, len_d;
    logic        rx_err_q, rx_err_d;
    counters_t   cnt_q, cnt_d;
    logic [15:0] last_len_q, last_len_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_good_q, frame_good_d;

    logic        pre_err_ev;
    logic        frame_end_ev;
    logic        sfd_ev;
    logic        crc_bad;
    logic        runt;
    logic        good;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_q),
        .data    (gmii_in.rxd),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_err_ev   = 1'b0;
        frame_end_ev = 1'b0;
        sfd_ev       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gmii_in.rx_dv) begin
                    if (!enable) begin
                        state_d = ST_DROP;
                    end else if (gmii_in.rxd == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d    = ST_DROP;
                        pre_err_ev = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                // pre_cnt_q is always 1..7 here, so an SFD is always acceptable
                if (gmii_in.rx_dv && gmii_in.rxd == SFD_BYTE) begin
                    state_d = ST_DATA;
                    sfd_ev  = 1'b1;
                end else if (gmii_in.rx_dv && gmii_in.rxd == PREAMBLE_BYTE
                             && pre_cnt_q != MAX_PREAMBLE) begin
                    state_d = ST_PREAMBLE;
                end else begin
                    state_d    = ST_DROP;
                    pre_err_ev = 1'b1;
                end
            end
            ST_DATA: begin
                if (!gmii_in.rx_dv) begin
                    state_d      = ST_IDLE;
                    frame_end_ev = 1'b1;
                end
            end
            ST_DROP: begin
                if (!gmii_in.rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The LSB-first register ends at the bit-reversed residue when the FCS matches.
    assign crc_bad = (reflect32(crc_q) != CRC_RESIDUE);
    assign runt    = (len_q < MIN_LEN_W);
    assign good    = !crc_bad && !runt && !rx_err_q;

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        crc_d        = crc_q;
        len_d        = len_q;
        rx_err_d     = rx_err_q;
        cnt_d        = cnt_q;
        last_len_d   = last_len_q;
        frame_done_d = frame_end_ev;
        frame_good_d = frame_good_q;

        if (state_q == ST_IDLE) begin
            pre_cnt_d = 3'd1;
        end else if (state_q == ST_PREAMBLE && pre_cnt_q != MAX_PREAMBLE) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
        end

        if (sfd_ev) begin
            crc_d    = CRC_INIT;
            len_d    = 16'd0;
            rx_err_d = 1'b0;
        end else if (state_q == ST_DATA && gmii_in.rx_dv) begin
            crc_d    = crc_next;
            len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
            rx_err_d = rx_err_q | gmii_in.rx_er;
        end

        if (pre_err_ev) begin
            cnt_d.preamble_err = cnt_q.preamble_err + 32'd1;
        end

        if (frame_end_ev) begin
            frame_good_d = good;
            last_len_d   = len_q;
            cnt_d.frames = cnt_q.frames + 32'd1;
            cnt_d.bytes  = cnt_q.bytes + {16'h0, len_q};
            if (good)     cnt_d.good    = cnt_q.good + 32'd1;
            if (crc_bad)  cnt_d.crc_err = cnt_q.crc_err + 32'd1;
            if (runt)     cnt_d.runt    = cnt_q.runt + 32'd1;
            if (rx_err_q) cnt_d.rx_err  = cnt_q.rx_err + 32'd1;
        end

        if (clear_counters) begin
            cnt_d      = '0;
            last_len_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q    <= 3'd1;
            crc_q        <= CRC_INIT;
            len_q        <= 16'd0;
            rx_err_q     <= 1'b0;
            cnt_q        <= '0;
            last_len_q   <= 16'd0;
            frame_done_q <= 1'b0;
            frame_good_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            rx_err_q     <= rx_err_d;
            cnt_q        <= cnt_d;
            last_len_q   <= last_len_d;
            frame_done_q <= frame_done_d;
            frame_good_q <= frame_good_d;
        end
    end

    assign frame_count        = cnt_q.frames;
    assign good_count         = cnt_q.good;
    assign crc_err_count      = cnt_q.crc_err;
    assign preamble_err_count = cnt_q.preamble_err;
    assign rx_err_count       = cnt_q.rx_err;
    assign runt_count         = cnt_q.runt;
    assign byte_count         = cnt_q.bytes;
    assign last_len           = last_len_q;
    assign frame_done         = frame_done_q;
    assign frame_good         = frame_good_q;

endmodule
